// File: rtl/result_select_arb.sv
// Registered N-to-1 result selector with a valid/ready handshake on every source and on the output.
// Supports fixed-priority or round-robin arbitration, plus a forced-select override.
module result_select_arb #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int MODE   = 0,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [SEL_W-1:0]  rr_ptr;
    logic [NUM_IN-1:0] fp_grant;
    logic [NUM_IN-1:0] upper_mask;
    logic [NUM_IN-1:0] masked_valid;
    logic [NUM_IN-1:0] masked_grant;
    logic [NUM_IN-1:0] rr_grant;
    logic [NUM_IN-1:0] force_grant;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  grant_data;
    logic [SEL_W-1:0]  next_ptr;
    logic              can_load;
    logic              accept;

    // x & -x isolates the lowest set bit; the round-robin search first looks at or above rr_ptr, then wraps.
    assign fp_grant     = in_valid & (~in_valid + NUM_IN'(1));
    assign upper_mask   = ~((NUM_IN'(1) << rr_ptr) - NUM_IN'(1));
    assign masked_valid = in_valid & upper_mask;
    assign masked_grant = masked_valid & (~masked_valid + NUM_IN'(1));
    assign rr_grant     = (|masked_valid) ? masked_grant : fp_grant;

    always_comb begin
        force_grant = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            force_grant[i] = in_valid[i] && (force_sel == SEL_W'(i));
        end
    end

    always_comb begin
        if (force_en) begin
            grant = force_grant;
        end else if (MODE == 1) begin
            grant = rr_grant;
        end else begin
            grant = fp_grant;
        end
    end

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                grant_idx  = grant_idx | SEL_W'(i);
                grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign next_ptr = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
    assign can_load = !out_valid || out_ready;
    assign in_ready = (rst_n && can_load) ? grant : '0;
    assign accept   = |in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant_idx;
            if (MODE == 1 && !force_en) begin
                rr_ptr <= next_ptr;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_select_arb.sv
// Drives three arbiter variants (fixed 8, round-robin 8, round-robin 5) with shared stimulus
// and compares them against a search-based reference model every cycle.
module tb_result_select_arb;

    logic         clk;
    logic         rst_n;
    logic [255:0] in_data;
    logic [7:0]   in_valid;
    logic         force_en;
    logic [2:0]   force_sel;
    logic         out_ready;

    logic [7:0]  ready0, ready1;
    logic [4:0]  ready2;
    logic [31:0] data0, data1, data2;
    logic [2:0]  sel0, sel1, sel2;
    logic        valid0, valid1, valid2;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    int          n_src[3] = '{8, 8, 5};
    int          mode[3]  = '{0, 1, 1};
    bit          m_valid[3];
    logic [31:0] m_data[3];
    int          m_sel[3];
    int          m_ptr[3];

    logic [7:0]  r_ready[3];
    logic [31:0] r_data[3];
    logic [2:0]  r_sel[3];
    logic        r_valid[3];

    result_select_arb #(.WIDTH(32), .NUM_IN(8), .MODE(0)) d0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ready0),
        .force_en(force_en), .force_sel(force_sel), .out_data(data0), .out_sel(sel0),
        .out_valid(valid0), .out_ready(out_ready)
    );

    result_select_arb #(.WIDTH(32), .NUM_IN(8), .MODE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ready1),
        .force_en(force_en), .force_sel(force_sel), .out_data(data1), .out_sel(sel1),
        .out_valid(valid1), .out_ready(out_ready)
    );

    result_select_arb #(.WIDTH(32), .NUM_IN(5), .MODE(1)) d2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[159:0]), .in_valid(in_valid[4:0]), .in_ready(ready2),
        .force_en(force_en), .force_sel(force_sel), .out_data(data2), .out_sel(sel2),
        .out_valid(valid2), .out_ready(out_ready)
    );

    assign r_ready[0] = ready0;
    assign r_ready[1] = ready1;
    assign r_ready[2] = {3'b000, ready2};
    assign r_data[0]  = data0;
    assign r_data[1]  = data1;
    assign r_data[2]  = data2;
    assign r_sel[0]   = sel0;
    assign r_sel[1]   = sel1;
    assign r_sel[2]   = sel2;
    assign r_valid[0] = valid0;
    assign r_valid[1] = valid1;
    assign r_valid[2] = valid2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: scan the sources in arbitration order and return the winner, or -1 if none.
    function automatic int model_grant(int k);
        int idx;
        if (force_en) begin
            if (int'(force_sel) < n_src[k] && in_valid[force_sel]) return int'(force_sel);
            return -1;
        end
        for (int j = 0; j < n_src[k]; j++) begin
            idx = (mode[k] == 1) ? (m_ptr[k] + j) % n_src[k] : j;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_ready(int k);
        int g;
        g = model_grant(k);
        if (!rst_n || g < 0 || (m_valid[k] && !out_ready)) return 8'h00;
        return 8'h01 << g;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_valid[k] <= 1'b0;
                m_data[k]  <= '0;
                m_sel[k]   <= 0;
                m_ptr[k]   <= 0;
            end else if (model_ready(k) != 8'h00) begin
                m_valid[k] <= 1'b1;
                m_data[k]  <= in_data[model_grant(k)*32 +: 32];
                m_sel[k]   <= model_grant(k);
                if (!force_en && mode[k] == 1) m_ptr[k] <= (model_grant(k) + 1) % n_src[k];
            end else if (out_ready) begin
                m_valid[k] <= 1'b0;
            end
        end
        started <= 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("cmp_ready_d%0d", k), {24'h0, r_ready[k]}, {24'h0, model_ready(k)});
                checkOutput($sformatf("cmp_valid_d%0d", k), {31'h0, r_valid[k]}, {31'h0, m_valid[k]});
                checkOutput($sformatf("cmp_data_d%0d", k), r_data[k], m_data[k]);
                checkOutput($sformatf("cmp_sel_d%0d", k), {29'h0, r_sel[k]}, m_sel[k]);
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic [7:0] valid, input logic fen,
                                 input logic [2:0] fsel, input logic ordy);
        rst_n     = rst;
        in_valid  = valid;
        force_en  = fen;
        force_sel = fsel;
        out_ready = ordy;
        #1;
    endtask

    task automatic setData(input logic [31:0] base);
        for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = base + 32'(i);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_seq[3] = '{7, 0, 7};
        in_data = '0;
        setData(32'hA000_0000);
        applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checkOutput("reset_ready_d0", {24'h0, ready0}, 32'h0);
            checkOutput("reset_ready_d1", {24'h0, ready1}, 32'h0);
            checkOutput("reset_ready_d2", {27'h0, ready2}, 32'h0);
            cycle();
        end

        applyStimulus(1'b1, 8'hFF, 1'b0, 3'd0, 1'b1);
        checkOutput("release_valid", {31'h0, valid1}, 32'h0);
        checkOutput("release_data", data1, 32'h0);
        checkOutput("release_sel", {29'h0, sel1}, 32'h0);
        checkOutput("release_ready_d1", {24'h0, ready1}, 32'h1);
        cycle();
        checkOutput("first_valid", {31'h0, valid1}, 32'h1);
        checkOutput("rr_sel_0", {29'h0, sel1}, 32'h0);
        for (int c = 1; c < 10; c++) begin
            cycle();
            checkOutput($sformatf("rr_sel_%0d", c), {29'h0, sel1}, 32'(c % 8));
            checkOutput($sformatf("rr_data_%0d", c), data1, 32'hA000_0000 + 32'(c % 8));
            checkOutput($sformatf("fp_sel_%0d", c), {29'h0, sel0}, 32'h0);
        end

        applyStimulus(1'b1, 8'h81, 1'b0, 3'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cycle();
            checkOutput($sformatf("rr_wrap_%0d", c), {29'h0, sel1}, 32'(rr_seq[c]));
        end

        applyStimulus(1'b1, 8'hA4, 1'b0, 3'd0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            checkOutput("fp_ready", {24'h0, ready0}, 32'h04);
            cycle();
            checkOutput("fp_sel", {29'h0, sel0}, 32'h2);
        end

        applyStimulus(1'b1, 8'hA4, 1'b0, 3'd0, 1'b0);
        setData(32'hB000_0000);
        #1;
        for (int c = 0; c < 4; c++) begin
            checkOutput("bp_ready_d0", {24'h0, ready0}, 32'h0);
            checkOutput("bp_ready_d1", {24'h0, ready1}, 32'h0);
            cycle();
            checkOutput("bp_data_d0", data0, 32'hA000_0002);
            checkOutput("bp_sel_d1", {29'h0, sel1}, 32'h5);
            checkOutput("bp_valid_d0", {31'h0, valid0}, 32'h1);
        end
        applyStimulus(1'b1, 8'hA4, 1'b0, 3'd0, 1'b1);
        checkOutput("bp_release_ready_d0", {24'h0, ready0}, 32'h04);
        checkOutput("bp_release_ready_d1", {24'h0, ready1}, 32'h80);
        cycle();
        checkOutput("bp_release_data_d0", data0, 32'hB000_0002);
        checkOutput("bp_release_data_d1", data1, 32'hB000_0007);

        applyStimulus(1'b1, 8'h08, 1'b0, 3'd0, 1'b1);
        cycle();
        checkOutput("ptr_setup_sel", {29'h0, sel1}, 32'h3);

        applyStimulus(1'b1, 8'h20, 1'b1, 3'd5, 1'b1);
        checkOutput("force_ready_d0", {24'h0, ready0}, 32'h20);
        checkOutput("force_ready_d1", {24'h0, ready1}, 32'h20);
        cycle();
        checkOutput("force_sel", {29'h0, sel1}, 32'h5);
        checkOutput("force_data", data1, 32'hB000_0005);
        applyStimulus(1'b1, 8'h01, 1'b1, 3'd5, 1'b1);
        checkOutput("force_none_d0", {24'h0, ready0}, 32'h0);
        checkOutput("force_none_d1", {24'h0, ready1}, 32'h0);
        cycle();
        checkOutput("force_drain_valid", {31'h0, valid1}, 32'h0);
        applyStimulus(1'b1, 8'hFF, 1'b1, 3'd6, 1'b1);
        checkOutput("force_range_d2", {27'h0, ready2}, 32'h0);
        checkOutput("force_range_d1", {24'h0, ready1}, 32'h40);
        cycle();
        applyStimulus(1'b1, 8'hFF, 1'b0, 3'd0, 1'b1);
        checkOutput("ptr_kept_ready", {24'h0, ready1}, 32'h10);
        cycle();
        checkOutput("ptr_kept_sel", {29'h0, sel1}, 32'h4);

        applyStimulus(1'b1, 8'h20, 1'b0, 3'd0, 1'b1);
        cycle();
        checkOutput("mid_setup_sel", {29'h0, sel1}, 32'h5);
        applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 1'b1);
        checkOutput("mid_reset_ready", {24'h0, ready1}, 32'h0);
        cycle();
        checkOutput("mid_reset_valid", {31'h0, valid1}, 32'h0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 3'd0, 1'b1);
        checkOutput("mid_first_ready", {24'h0, ready1}, 32'h01);
        cycle();
        checkOutput("mid_first_sel", {29'h0, sel1}, 32'h0);
        checkOutput("mid_first_valid", {31'h0, valid1}, 32'h1);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = $urandom;
            applyStimulus($urandom_range(0, 99) != 0,
                          ($urandom_range(0, 1) == 0) ? 8'($urandom & $urandom) : 8'($urandom),
                          $urandom_range(0, 7) == 0,
                          3'($urandom),
                          $urandom_range(0, 3) != 0);
            cycle();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
